// File: rtl/pkt_pkg.sv
// Shared constants, state encoding and frame helpers for the packet handler.
// The frame is an 8-byte array indexed by arrival order (index 0 is the start byte).
package pkt_pkg;

    localparam int FRAME_BYTES = 8;
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    localparam logic [7:0] SOF      = 8'h96;
    localparam logic [7:0] CMD_DATA = 8'h0F;
    localparam logic [7:0] CMD_KILL = 8'hF0;
    localparam logic [7:0] BCAST_ID = 8'hFF;

    localparam int IDX_SOF   = 0;
    localparam int IDX_CMD   = 1;
    localparam int IDX_DST   = 2;
    localparam int IDX_SRC   = 3;
    localparam int IDX_PL_HI = 4;
    localparam int IDX_PL_LO = 5;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        DONE
    } state_t;

    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    function automatic logic dest_match(input logic [7:0] dst, input logic [7:0] veh_id);
        return (dst == veh_id) || (dst == BCAST_ID);
    endfunction

    function automatic logic [15:0] frame_payload(input frame_t f);
        return {f[IDX_PL_HI], f[IDX_PL_LO]};
    endfunction

endpackage

// File: rtl/pkt_deframer.sv
// Collects bytes into fixed-length frames: hunts for the start byte, gathers
// the remaining bytes, then spends one DONE cycle not accepting input.
module pkt_deframer
    import pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_frame,
    input  logic       rx_valid,
    output logic       rx_ready,
    output frame_t     frame,
    output logic       frame_done
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    frame_t            frame_q;
    frame_t            frame_next;
    logic              accept;
    logic              last_byte;
    logic              take_byte;

    assign accept     = rx_valid && rx_ready;
    assign last_byte  = accept && (state == COLLECT) && (count == CNT_W'(FRAME_BYTES - 1));
    assign take_byte  = accept && ((state == COLLECT) || ((state == HUNT) && (rx_frame == SOF)));
    assign frame_done = last_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (accept && (rx_frame == SOF)) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = HUNT;
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Ready is held low during reset so nothing is consumed before the FSM is known.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            HUNT, COLLECT: rx_ready = !rst;
            default:       rx_ready = 1'b0;
        endcase
    end

    // The outgoing frame includes the byte being accepted this edge, so the
    // decoder can evaluate on the same edge that takes the final byte.
    always_comb begin
        frame_next = frame_q;
        if (take_byte) begin
            frame_next[count[IDX_W-1:0]] = rx_frame;
        end
    end

    assign frame = frame_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            frame_q <= '0;
        end else begin
            frame_q <= frame_next;
            case (state)
                HUNT: begin
                    if (take_byte) begin
                        count <= CNT_W'(1);
                    end else begin
                        count <= '0;
                    end
                end
                COLLECT: begin
                    if (last_byte) begin
                        count <= '0;
                    end else if (accept) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pkt_handler.sv
// Frame decoder: filters completed frames by destination ID and drives the
// data payload/strobe and the sticky kill request.
module pkt_handler
    import pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  veh_id,
    input  logic [7:0]  rx_frame,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        kill
);

    frame_t frame;
    logic   frame_done;
    logic   frame_match;
    logic   unused_bytes;

    pkt_deframer u_deframer (
        .clk        (clk),
        .rst        (rst),
        .rx_frame   (rx_frame),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame      (frame),
        .frame_done (frame_done)
    );

    assign frame_match  = frame_done && dest_match(frame[IDX_DST], veh_id);
    assign unused_bytes = ^{frame[IDX_SOF], frame[IDX_SRC], frame[FRAME_BYTES-1:IDX_PL_LO+1]};

    // data_valid lands in the DONE cycle; kill only ever sets until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= 16'h0000;
            data_valid <= 1'b0;
            kill       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (frame_match) begin
                case (frame[IDX_CMD])
                    CMD_DATA: begin
                        data       <= frame_payload(frame);
                        data_valid <= 1'b1;
                    end
                    CMD_KILL: begin
                        kill <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_handler.sv
// Scoreboard bench for pkt_handler: a byte-level reference model pushes
// expected payloads when frames complete; a negedge monitor pops and compares.
module tb_pkt_handler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  veh_id = 8'h01;
    logic [7:0]  rx_frame = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] data;
    logic        data_valid;
    logic        kill;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_q[$];
    int          m_cnt = 0;
    logic [7:0]  m_buf[8];
    logic [15:0] exp_data = 16'h0000;
    logic        exp_kill = 1'b0;
    bit          frame_end = 1'b0;

    pkt_handler dut (
        .clk        (clk),
        .rst        (rst),
        .veh_id     (veh_id),
        .rx_frame   (rx_frame),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .data       (data),
        .data_valid (data_valid),
        .kill       (kill)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model of one accepted byte.
    task automatic modelByte(input logic [7:0] b);
        if (m_cnt == 0) begin
            if (b == 8'h96) begin
                m_buf[0] = b;
                m_cnt    = 1;
            end
        end else begin
            m_buf[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt     = 0;
                frame_end = 1'b1;
                if (m_buf[2] == veh_id || m_buf[2] == 8'hFF) begin
                    if (m_buf[1] == 8'h0F) begin
                        exp_data = {m_buf[4], m_buf[5]};
                        sb_q.push_back(exp_data);
                    end else if (m_buf[1] == 8'hF0) begin
                        exp_kill = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waits;
        waits = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_frame = b;
        while (!rx_ready && waits < 16) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        frame_end = 1'b0;
        modelByte(b);
        if (frame_end) begin
            @(negedge clk);
            rx_valid = 1'b0;
            checkOutput("ready_in_done", rx_ready, 32'd0);
        end
    endtask

    task automatic sendFrame(input logic [63:0] f);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(f[63-8*i -: 8]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_frame = 8'h96;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        m_cnt    = 0;
        exp_data = 16'h0000;
        exp_kill = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checkOutput("ready_in_rst", rx_ready, 32'd0);
        @(negedge clk);
        checkOutput("rst_data", data, 32'h0000);
        checkOutput("rst_dv", data_valid, 32'd0);
        checkOutput("rst_kill", kill, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", rx_ready, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                checkOutput("dv_ready_low", rx_ready, 32'd0);
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_dv", 32'd1, 32'd0);
                end else begin
                    checkOutput("data_strobe", data, sb_q.pop_front());
                end
            end
            checkOutput("data_hold", data, exp_data);
            checkOutput("kill", kill, exp_kill);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        veh_id = 8'h01;
        doReset();
        idle(2);

        sendFrame(64'hFFFF_FFFF_FFFF_FFFF);
        sendFrame(64'h960F_0173_A758_3362);
        idle(2);
        checkOutput("after_first", data, 32'hA758);

        sendFrame(64'h960F_0200_0001_BEEF);
        idle(2);
        checkOutput("wrong_dest", data, 32'hA758);
        sendFrame(64'h960F_FF00_1234_0000);
        idle(2);
        checkOutput("broadcast", data, 32'h1234);

        sendFrame(64'h96F0_0100_0000_0000);
        idle(2);
        checkOutput("kill_set", kill, 32'd1);
        sendFrame(64'h960F_0100_55AA_0000);
        idle(2);
        checkOutput("data_under_kill", data, 32'h55AA);
        checkOutput("kill_held", kill, 32'd1);
        doReset();

        applyStimulus(8'h96);
        applyStimulus(8'h0F);
        applyStimulus(8'h01);
        applyStimulus(8'h73);
        idle(3);
        applyStimulus(8'hA7);
        applyStimulus(8'h58);
        applyStimulus(8'h33);
        applyStimulus(8'h62);
        idle(2);
        checkOutput("gapped", data, 32'hA758);

        applyStimulus(8'h96);
        applyStimulus(8'h0F);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        doReset();
        sendFrame(64'h960F_0100_0001_0000);
        idle(3);
        checkOutput("after_midreset", data, 32'h0001);

        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_handler.md
Name: pkt_handler

Overview:
- Receives a byte stream from the radio/UART receive path and assembles fixed 8-byte frames, most significant byte first.
- Filters each frame by start byte and destination vehicle ID, then decodes it.
- A DATA frame presents a 16-bit payload with a one-cycle valid strobe.
- A KILL frame asserts a sticky kill output to the vehicle control logic.

Parameters:
- FRAME_BYTES, 8, bytes per frame.
- SOF, 8'h96, required value of byte 0.
- CMD_DATA, 8'h0F, command code for a data frame.
- CMD_KILL, 8'hF0, command code for a kill frame.
- BCAST_ID, 8'hFF, destination ID accepted by every vehicle.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- veh_id  in  8  this vehicle's ID; static during operation; compared live at end of frame.
- rx_frame  in  8  received byte.
- rx_valid  in  1  rx_frame holds a valid byte.
- rx_ready  out  1  handler can accept a byte.
- data  out  16  last accepted DATA payload.
- data_valid  out  1  one-cycle strobe; data is new.
- kill  out  1  sticky kill request.

Behaviour:
- Frame layout, bytes in arrival order:
  - B0 = SOF
  - B1 = command
  - B2 = destination ID
  - B3 = source ID (ignored)
  - B4 = payload[15:8]
  - B5 = payload[7:0]
  - B6, B7 reserved (ignored)
- A byte is accepted on a rising edge where rx_valid && rx_ready. No other edge consumes input.
- States:
  - HUNT: rx_ready=1, count=0. An accepted byte equal to SOF moves to COLLECT with count=1. Any other accepted byte is discarded and the state stays HUNT, so the block resynchronises on garbage such as all-FF.
  - COLLECT: rx_ready=1. Each accepted byte is stored in shift/byte registers and increments count. rx_valid low stalls with no timeout. When the 8th byte (count reaches FRAME_BYTES) is accepted, evaluate the frame on that same edge and go to DONE.
  - DONE: lasts exactly 1 cycle with rx_ready=0, then returns to HUNT.
- Evaluation is performed on the edge that accepts the 8th byte. The frame matches if dest==veh_id or dest==BCAST_ID.
  - Match with cmd==CMD_DATA: data<=payload; data_valid<=1 for exactly the DONE cycle.
  - Match with cmd==CMD_KILL: kill<=1. kill holds until rst. data and data_valid are untouched.
  - Non-matching destination or unknown command: frame dropped silently; no output changes.
- Latency: data_valid and kill become visible in the cycle immediately after the edge accepting B7.
- data holds its value between frames.
- data_valid is 0 in every cycle except DONE after a matching DATA frame.
- A second kill frame has no further effect. Data frames are still processed while kill=1.
- Reset values: rx_ready=0 while rst=1 and 1 in the first cycle after release. data=16'h0000, data_valid=0, kill=0, state=HUNT, count=0.
- Reset mid-frame discards the partial frame.
- rx_frame content while rx_valid=0 is don't-care, including X.
- A SOF value appearing mid-frame is treated as ordinary data; no resync inside COLLECT.

Decomposition:
- Package pkt_pkg holds:
  - FRAME_BYTES, SOF, CMD_DATA, CMD_KILL, BCAST_ID constants
  - state enum {HUNT, COLLECT, DONE}
  - byte-index constants (IDX_CMD=1, IDX_DST=2, IDX_PL_HI=4, IDX_PL_LO=5)
- One optional sub-module, pkt_deframer: byte collection, count, and HUNT/COLLECT/DONE control. It outputs the 8-byte frame plus a frame_done pulse. pkt_handler adds the decode and output registers.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> data=0000, data_valid=0, kill=0, rx_ready=1 the next cycle.
- veh_id=01; send FFFFFFFFFFFFFFFF, then 960F0173A7583362 back-to-back -> first frame yields nothing. After the second frame's last byte: data=A758, data_valid high exactly 1 cycle, rx_ready low that cycle, kill=0.
- veh_id=01; send 960F02000001BEEF -> dropped; data unchanged, no strobe. Then send 960FFF001234 0000 (broadcast) -> data=1234 with strobe.
- veh_id=01; send 96F0010000000000 -> kill=1 one cycle after B7 and stays 1. A following DATA frame 960F010055AA0000 -> data=55AA, kill still 1. Then rst -> kill=0.
- Gapped input: drop rx_valid for 3 cycles between B3 and B4 of 960F0173A7583362 -> identical result (A758), no byte duplicated or lost.
- Reset mid-frame after B3, then send a full 960F010000010000 -> data=0001. The partial frame produces no output.
